// File: rtl/lsq_stq_drain.sv
// lsq_stq_drain: drain sequencer for retired store bundles.
// Buffers retired bundles in a FIFO. Each bundle is a 6-slot store mask with an II tag.
// The stores of the head bundle go out in ascending slot order on two cache write ports,
// at most two per cycle and never mixing bundles.
// A one-cycle done pulse reports each bundle once its last stores have been issued.
module lsq_stq_drain #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_en,
   input  logic [5:0]       push_mask,
   input  logic [5:0]       push_II,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   input  logic             wr_stall,
   output logic             wr0_en,
   output logic [2:0]       wr0_slot,
   output logic [5:0]       wr0_II,
   output logic             wr1_en,
   output logic [2:0]       wr1_slot,
   output logic [5:0]       wr1_II,
   output logic             done_en,
   output logic [5:0]       done_II
);

   localparam int PTR_W = $clog2(DEPTH);

   // Isolate the lowest set bit of a store mask as a one-hot value.
   function automatic logic [5:0] lowest_bit(input logic [5:0] m);
      return m & (~m + 6'd1);
   endfunction

   // Return the index of the lowest set bit of a store mask, or 0 when the mask is empty.
   function automatic logic [2:0] lowest_idx(input logic [5:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (m[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Bundle storage. Each entry is an II tag plus the slots that remain to be written.
   logic [5:0]       ii_q   [DEPTH];
   logic [5:0]       mask_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // Registered write-port and completion outputs.
   logic             wr0_en_q, wr0_en_d;
   logic [2:0]       wr0_slot_q, wr0_slot_d;
   logic [5:0]       wr0_II_q, wr0_II_d;
   logic             wr1_en_q, wr1_en_d;
   logic [2:0]       wr1_slot_q, wr1_slot_d;
   logic [5:0]       wr1_II_q, wr1_II_d;
   logic             done_en_q, done_en_d;
   logic [5:0]       done_II_q, done_II_d;

   // Head decode and issue, pop and push decisions.
   logic [5:0] head_mask_s;
   logic [5:0] head_ii_s;
   logic       full_s;
   logic       head_valid_s;
   logic       issue_s;
   logic [5:0] b0_s;
   logic [5:0] rest_s;
   logic [5:0] b1_s;
   logic [5:0] cleared_s;
   logic [2:0] s0_s;
   logic [2:0] s1_s;
   logic       has_s1_s;
   logic       pop_s;
   logic       push_valid_s;
   logic       push_acc_s;

   // Pick the two lowest pending slots of the head and derive the pop and push decisions.
   always_comb begin
      head_mask_s  = mask_q[head_q];
      head_ii_s    = ii_q[head_q];
      full_s       = (count_q == CNT_W'(DEPTH));
      head_valid_s = (count_q != {CNT_W{1'b0}});
      issue_s      = head_valid_s && !wr_stall;
      b0_s         = lowest_bit(head_mask_s);
      rest_s       = head_mask_s & ~b0_s;
      b1_s         = lowest_bit(rest_s);
      cleared_s    = rest_s & ~b1_s;
      s0_s         = lowest_idx(head_mask_s);
      s1_s         = lowest_idx(rest_s);
      has_s1_s     = (rest_s != 6'd0);
      pop_s        = issue_s && (cleared_s == 6'd0);
      push_valid_s = push_en && (push_mask != 6'd0);
      // A full FIFO still takes a push when the head frees its entry in the same cycle.
      push_acc_s   = push_valid_s && (!full_s || pop_s);
   end

   // Next-state for the pointers, the occupancy count and the sticky overflow flag.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (pop_s) begin
         head_d = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end
      if (push_acc_s) begin
         tail_d = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end
      if (push_acc_s && !pop_s) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_s && !push_acc_s) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end
      if (push_valid_s && !push_acc_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Next-state for the write ports and the done pulse. Slot and II hold while idle.
   always_comb begin
      wr0_en_d   = issue_s;
      wr0_slot_d = wr0_slot_q;
      wr0_II_d   = wr0_II_q;
      wr1_en_d   = issue_s && has_s1_s;
      wr1_slot_d = wr1_slot_q;
      wr1_II_d   = wr1_II_q;
      done_en_d  = pop_s;
      done_II_d  = done_II_q;
      if (issue_s) begin
         wr0_slot_d = s0_s;
         wr0_II_d   = head_ii_s;
      end else begin
         wr0_slot_d = wr0_slot_q;
         wr0_II_d   = wr0_II_q;
      end
      if (issue_s && has_s1_s) begin
         wr1_slot_d = s1_s;
         wr1_II_d   = head_ii_s;
      end else begin
         wr1_slot_d = wr1_slot_q;
         wr1_II_d   = wr1_II_q;
      end
      if (pop_s) begin
         done_II_d = head_ii_s;
      end else begin
         done_II_d = done_II_q;
      end
   end

   // Bundle storage update. When full with a simultaneous pop, tail equals head and the push wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ii_q[i]   <= 6'd0;
            mask_q[i] <= 6'd0;
         end
      end else begin
         if (issue_s) begin
            mask_q[head_q] <= cleared_s;
         end
         if (push_acc_s) begin
            mask_q[tail_q] <= push_mask;
            ii_q[tail_q]   <= push_II;
         end
      end
   end

   // Control and output register update.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= {PTR_W{1'b0}};
         tail_q     <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         ovf_q      <= 1'b0;
         wr0_en_q   <= 1'b0;
         wr0_slot_q <= 3'd0;
         wr0_II_q   <= 6'd0;
         wr1_en_q   <= 1'b0;
         wr1_slot_q <= 3'd0;
         wr1_II_q   <= 6'd0;
         done_en_q  <= 1'b0;
         done_II_q  <= 6'd0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         wr0_en_q   <= wr0_en_d;
         wr0_slot_q <= wr0_slot_d;
         wr0_II_q   <= wr0_II_d;
         wr1_en_q   <= wr1_en_d;
         wr1_slot_q <= wr1_slot_d;
         wr1_II_q   <= wr1_II_d;
         done_en_q  <= done_en_d;
         done_II_q  <= done_II_d;
      end
   end

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == {CNT_W{1'b0}});
   assign count    = count_q;
   assign ovf      = ovf_q;
   assign wr0_en   = wr0_en_q;
   assign wr0_slot = wr0_slot_q;
   assign wr0_II   = wr0_II_q;
   assign wr1_en   = wr1_en_q;
   assign wr1_slot = wr1_slot_q;
   assign wr1_II   = wr1_II_q;
   assign done_en  = done_en_q;
   assign done_II  = done_II_q;

endmodule

// File: tb/tb_lsq_stq_drain.sv
// Testbench for lsq_stq_drain: directed scenarios plus random traffic, checked against a
// queue-of-bundles reference model.
module tb_lsq_stq_drain;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic             push_en;
   logic [5:0]       push_mask;
   logic [5:0]       push_II;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             wr_stall;
   logic             wr0_en;
   logic [2:0]       wr0_slot;
   logic [5:0]       wr0_II;
   logic             wr1_en;
   logic [2:0]       wr1_slot;
   logic [5:0]       wr1_II;
   logic             done_en;
   logic [5:0]       done_II;

   lsq_stq_drain #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .push_en(push_en), .push_mask(push_mask), .push_II(push_II),
      .full(full), .empty(empty), .count(count), .ovf(ovf),
      .wr_stall(wr_stall),
      .wr0_en(wr0_en), .wr0_slot(wr0_slot), .wr0_II(wr0_II),
      .wr1_en(wr1_en), .wr1_slot(wr1_slot), .wr1_II(wr1_II),
      .done_en(done_en), .done_II(done_II)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] ii;
      logic [5:0] mask;
   } bundle_t;

   bundle_t    mq[$];
   logic       e_ovf;
   logic       e_wr0_en, e_wr1_en, e_done_en;
   logic [2:0] e_wr0_slot, e_wr1_slot;
   logic [5:0] e_wr0_ii, e_wr1_ii, e_done_ii;
   logic       e_after_rst;
   int         n_checks;
   int         n_fail;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: apply one clock edge to the bundle queue using the current inputs.
   task automatic model_edge();
      bundle_t b;
      int      n;
      e_wr0_en    = 1'b0;
      e_wr1_en    = 1'b0;
      e_done_en   = 1'b0;
      e_after_rst = 1'b0;
      if (rst) begin
         mq.delete();
         e_ovf       = 1'b0;
         e_wr0_slot  = 3'd0; e_wr0_ii = 6'd0;
         e_wr1_slot  = 3'd0; e_wr1_ii = 6'd0;
         e_done_ii   = 6'd0;
         e_after_rst = 1'b1;
         return;
      end
      if (mq.size() > 0 && !wr_stall) begin
         b = mq[0];
         n = 0;
         for (int k = 0; k < 6; k++) begin
            if (b.mask[k] && n < 2) begin
               if (n == 0) begin
                  e_wr0_en = 1'b1; e_wr0_slot = 3'(k); e_wr0_ii = b.ii;
               end else begin
                  e_wr1_en = 1'b1; e_wr1_slot = 3'(k); e_wr1_ii = b.ii;
               end
               b.mask[k] = 1'b0;
               n++;
            end
         end
         if (b.mask == 6'd0) begin
            e_done_en = 1'b1;
            e_done_ii = b.ii;
            void'(mq.pop_front());
         end else begin
            mq[0] = b;
         end
      end
      if (push_en && push_mask != 6'd0) begin
         if (mq.size() < DEPTH) begin
            b.ii   = push_II;
            b.mask = push_mask;
            mq.push_back(b);
         end else begin
            e_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("count", 32'(count), 32'(mq.size()));
      check_eq("empty", 32'(empty), 32'(mq.size() == 0));
      check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
      check_eq("ovf", 32'(ovf), 32'(e_ovf));
      check_eq("wr0_en", 32'(wr0_en), 32'(e_wr0_en));
      check_eq("wr1_en", 32'(wr1_en), 32'(e_wr1_en));
      check_eq("done_en", 32'(done_en), 32'(e_done_en));
      if (e_wr0_en || e_after_rst) begin
         check_eq("wr0_slot", 32'(wr0_slot), 32'(e_wr0_slot));
         check_eq("wr0_II", 32'(wr0_II), 32'(e_wr0_ii));
      end
      if (e_wr1_en || e_after_rst) begin
         check_eq("wr1_slot", 32'(wr1_slot), 32'(e_wr1_slot));
         check_eq("wr1_II", 32'(wr1_II), 32'(e_wr1_ii));
      end
      if (e_done_en || e_after_rst) begin
         check_eq("done_II", 32'(done_II), 32'(e_done_ii));
      end
   endtask

   // One clock: update the model, let the edge pass, check, then clear the one-shot inputs.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
      push_en   = 1'b0;
      push_mask = 6'd0;
      push_II   = 6'd0;
   endtask

   task automatic do_push(input logic [5:0] m, input logic [5:0] ii);
      push_en   = 1'b1;
      push_mask = m;
      push_II   = ii;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; push_en = 1'b0; push_mask = 6'd0; push_II = 6'd0; wr_stall = 1'b0;
      e_ovf = 1'b0;
      do_reset();

      // Reset, then idle.
      for (int i = 0; i < 5; i++) step();
      check_eq("idle_empty", 32'(empty), 32'd1);

      // Two-cycle bundle 101101.
      do_push(6'b101101, 6'h12);
      step();
      step();
      check_eq("b1_c2_s0", 32'(wr0_slot), 32'd0);
      check_eq("b1_c2_s1", 32'(wr1_slot), 32'd2);
      step();
      check_eq("b1_c3_s0", 32'(wr0_slot), 32'd3);
      check_eq("b1_c3_s1", 32'(wr1_slot), 32'd5);
      check_eq("b1_c3_done", 32'(done_II), 32'h12);
      step();
      check_eq("b1_c4_empty", 32'(empty), 32'd1);

      // Full bundle with a three-cycle stall.
      do_push(6'b111111, 6'h05);
      step();
      wr_stall = 1'b1;
      for (int i = 0; i < 3; i++) step();
      wr_stall = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // Overflow: five single-store bundles while stalled.
      wr_stall = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         do_push(6'b000100, 6'(i));
         step();
      end
      check_eq("ovf_count", 32'(count), 32'd4);
      check_eq("ovf_full", 32'(full), 32'd1);
      check_eq("ovf_flag", 32'(ovf), 32'd1);
      wr_stall = 1'b0;
      for (int i = 0; i < 6; i++) step();
      do_reset();

      // Push into a full FIFO in the cycle the head pops.
      wr_stall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         do_push(6'b010000, 6'(i));
         step();
      end
      wr_stall = 1'b0;
      do_push(6'b000011, 6'h2A);
      step();
      check_eq("fp_count", 32'(count), 32'd4);
      check_eq("fp_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 6; i++) step();

      // Zero mask push is ignored.
      do_push(6'b000000, 6'h33);
      step();
      step();
      check_eq("zero_count", 32'(count), 32'd0);

      // Reset in the middle of a full bundle.
      do_push(6'b111111, 6'h3C);
      step();
      step();
      step();
      do_reset();
      for (int i = 0; i < 4; i++) step();

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 299) == 0);
         wr_stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) begin
            do_push(($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom), 6'($urandom));
         end
         step();
      end
      rst = 1'b0;
      wr_stall = 1'b0;
      for (int i = 0; i < 20; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
